// File: rtl/hs_port_arbiter.sv
// hs_port_arbiter: pauses the CPU and time-shares the core's single debug/hiscore RAM
// port between two requesters, granting one session and one single-byte access at a time.
module hs_port_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    output logic          gnt_a,
    output logic          gnt_b,
    input  logic          acc_valid_a,
    input  logic          acc_we_a,
    input  logic [AW-1:0] acc_addr_a,
    input  logic [DW-1:0] acc_wdata_a,
    output logic          acc_ack_a,
    input  logic          acc_valid_b,
    input  logic          acc_we_b,
    input  logic [AW-1:0] acc_addr_b,
    input  logic [DW-1:0] acc_wdata_b,
    output logic          acc_ack_b,
    output logic [DW-1:0] acc_rdata,
    output logic          pause_req,
    input  logic          paused,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_write,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE_WAIT, S_SETTLE, S_GRANT, S_READ, S_WRITE, S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;     // 0 = A, 1 = B
    logic          last_b_q, last_b_d;   // last served requester was B
    logic [3:0]    scnt_q, scnt_d;
    logic [2:0]    lcnt_q, lcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic          pause_q, pause_d, wr_q, wr_d;

    logic          own_req, own_valid, own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          done, in_session;

    assign own_req   = owner_q ? req_b       : req_a;
    assign own_valid = owner_q ? acc_valid_b : acc_valid_a;
    assign own_we    = owner_q ? acc_we_b    : acc_we_a;
    assign own_addr  = owner_q ? acc_addr_b  : acc_addr_a;
    assign own_wdata = owner_q ? acc_wdata_b : acc_wdata_a;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_b_d = last_b_q;
        scnt_d   = scnt_q;
        lcnt_d   = lcnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    owner_d = (req_a && req_b) ? ~last_b_q : req_b;
                    state_d = S_PAUSE_WAIT;
                end
            end
            S_PAUSE_WAIT: begin
                if (!own_req) begin
                    state_d = S_RELEASE;
                end else if (paused) begin
                    state_d = S_SETTLE;
                    scnt_d  = '0;
                end
            end
            S_SETTLE: begin
                if (!own_req) begin
                    state_d = S_RELEASE;
                end else if (!paused) begin
                    state_d = S_PAUSE_WAIT;
                    scnt_d  = '0;
                end else if (scnt_q == 4'(SETTLE - 1)) begin
                    state_d = S_GRANT;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            S_GRANT: begin
                // Session loss is honoured before a new access so none starts unpaused.
                if (!own_req) begin
                    state_d = S_RELEASE;
                end else if (!paused) begin
                    state_d = S_PAUSE_WAIT;
                end else if (own_valid) begin
                    addr_d = own_addr;
                    lcnt_d = '0;
                    if (own_we) begin
                        wdata_d = own_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                done    = 1'b1;
                state_d = S_GRANT;
            end
            S_READ: begin
                if (lcnt_q == 3'(RD_LAT - 1)) begin
                    rdata_d = ram_rdata;
                    done    = 1'b1;
                    state_d = S_GRANT;
                end else begin
                    lcnt_d = lcnt_q + 3'd1;
                end
            end
            S_RELEASE: begin
                if (!paused) begin
                    last_b_d = owner_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_session = state_d inside {S_GRANT, S_READ, S_WRITE};
        gnt_a_d    = in_session && !owner_d;
        gnt_b_d    = in_session && owner_d;
        ack_a_d    = done && !owner_q;
        ack_b_d    = done && owner_q;
        pause_d    = state_d inside {S_PAUSE_WAIT, S_SETTLE, S_GRANT, S_READ, S_WRITE};
        wr_d       = (state_d == S_WRITE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_b_q <= 1'b1;
            scnt_q   <= '0;
            lcnt_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            pause_q  <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_b_q <= last_b_d;
            scnt_q   <= scnt_d;
            lcnt_q   <= lcnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            pause_q  <= pause_d;
            wr_q     <= wr_d;
        end
    end

    assign gnt_a       = gnt_a_q;
    assign gnt_b       = gnt_b_q;
    assign acc_ack_a   = ack_a_q;
    assign acc_ack_b   = ack_b_q;
    assign acc_rdata   = rdata_q;
    assign pause_req   = pause_q;
    assign ram_address = addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_write   = wr_q;

endmodule
